// File: rtl/bowling_game_ctrl.sv
// Bowling game sequencer: accepts pinsetter balls, checks them against frame
// rules, strobes the per-player scorers and runs the end-of-game scoring pass.
module bowling_game_ctrl #(
  parameter int MAX_PLAYERS  = 4,
  parameter int PW           = 2,
  parameter int SCORE_CYCLES = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [PW:0]   num_players,
  input  logic          ball_valid,
  input  logic [3:0]    ball_pins,
  output logic          ball_ready,
  output logic          roll,
  output logic [3:0]    pin_count,
  output logic [PW-1:0] player_sel,
  output logic          score_clear,
  output logic          calculate_score,
  output logic [3:0]    frame,
  output logic [1:0]    ball_num,
  output logic          error,
  output logic          game_over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ROLL  = 3'd3;
  localparam logic [2:0] S_SCORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int            CW      = $clog2(SCORE_CYCLES + 1);
  localparam logic [CW-1:0] SC_LAST = CW'(SCORE_CYCLES - 1);
  localparam logic [PW:0]   MAXP    = (PW+1)'(MAX_PLAYERS);

  logic [2:0]    state;
  logic [PW-1:0] last_p;
  logic [3:0]    pin_q;
  logic [3:0]    ball1;
  logic [3:0]    ball2;
  logic [CW-1:0] score_cnt;
  logic          err_q;

  logic [PW:0]   np_clamp;
  logic [4:0]    sum12;
  logic [4:0]    sum1q;
  logic [3:0]    standing;
  logic          legal;
  logic          frame_end;

  assign ball_ready      = (state == S_WAIT);
  assign roll            = (state == S_ROLL);
  assign pin_count       = roll ? pin_q : 4'd0;
  assign score_clear     = (state == S_CLEAR);
  assign calculate_score = (state == S_SCORE);
  assign game_over       = (state == S_DONE);
  assign error           = err_q;

  // 0 players means a solo game; anything beyond the scorer bank is clamped
  always_comb begin
    np_clamp = num_players;
    if (num_players == '0)       np_clamp = (PW+1)'(1);
    else if (num_players > MAXP) np_clamp = MAXP;
  end

  assign sum12 = {1'b0, ball1} + {1'b0, ball2};
  assign sum1q = {1'b0, ball1} + {1'b0, pin_q};

  // Pins still up before this ball; frame 10 re-racks after a strike or spare
  always_comb begin
    standing = 4'd10;
    if (ball_num == 2'd2) begin
      if (!(frame == 4'd10 && ball1 == 4'd10)) standing = 4'd10 - ball1;
    end else if (ball_num == 2'd3) begin
      if (!(sum12 == 5'd10 || ball2 == 4'd10)) standing = 4'd10 - ball2;
    end
    legal = (ball_pins <= 4'd10) && (ball_pins <= standing);
  end

  always_comb begin
    frame_end = 1'b0;
    if (frame != 4'd10)
      frame_end = (ball_num == 2'd1 && pin_q == 4'd10) || (ball_num == 2'd2);
    else if (ball_num == 2'd2)
      frame_end = !(ball1 == 4'd10 || sum1q == 5'd10);
    else
      frame_end = (ball_num == 2'd3);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      last_p     <= '0;
      pin_q      <= 4'd0;
      ball1      <= 4'd0;
      ball2      <= 4'd0;
      score_cnt  <= '0;
      err_q      <= 1'b0;
      frame      <= 4'd0;
      ball_num   <= 2'd0;
      player_sel <= '0;
    end else begin
      err_q <= 1'b0;
      if (start) begin
        state      <= S_CLEAR;
        last_p     <= PW'(np_clamp - (PW+1)'(1));
        frame      <= 4'd1;
        ball_num   <= 2'd1;
        player_sel <= '0;
        score_cnt  <= '0;
        ball1      <= 4'd0;
        ball2      <= 4'd0;
      end else begin
        case (state)
          S_CLEAR: state <= S_WAIT;
          S_WAIT: begin
            if (ball_valid) begin
              if (legal) begin
                pin_q <= ball_pins;
                state <= S_ROLL;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_ROLL: begin
            state <= S_WAIT;
            if (!frame_end) begin
              ball_num <= ball_num + 2'd1;
              if (ball_num == 2'd1) ball1 <= pin_q;
              else                  ball2 <= pin_q;
            end else if (player_sel != last_p) begin
              player_sel <= player_sel + PW'(1);
              ball_num   <= 2'd1;
            end else if (frame == 4'd10) begin
              // final frame/ball stay visible through scoring
              state      <= S_SCORE;
              player_sel <= '0;
              score_cnt  <= '0;
            end else begin
              player_sel <= '0;
              frame      <= frame + 4'd1;
              ball_num   <= 2'd1;
            end
          end
          S_SCORE: begin
            if (score_cnt == SC_LAST) begin
              score_cnt <= '0;
              if (player_sel == last_p) state <= S_DONE;
              else                      player_sel <= player_sel + PW'(1);
            end else begin
              score_cnt <= score_cnt + CW'(1);
            end
          end
          S_DONE: state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bowling_game_ctrl.sv
// Directed bench for bowling_game_ctrl: hand-computed frame/ball/player
// sequences, strobe counts from a negedge monitor, one checking task.
module tb_bowling_game_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] num_players = 3'd0;
  logic       ball_valid = 1'b0;
  logic [3:0] ball_pins = 4'd0;
  logic       ball_ready, roll, score_clear, calculate_score, error, game_over;
  logic [3:0] pin_count, frame;
  logic [1:0] player_sel, ball_num;

  bowling_game_ctrl #(.MAX_PLAYERS(4), .PW(2), .SCORE_CYCLES(10)) dut (
    .clock(clock), .reset(reset), .start(start), .num_players(num_players),
    .ball_valid(ball_valid), .ball_pins(ball_pins), .ball_ready(ball_ready),
    .roll(roll), .pin_count(pin_count), .player_sel(player_sel),
    .score_clear(score_clear), .calculate_score(calculate_score),
    .frame(frame), .ball_num(ball_num), .error(error), .game_over(game_over)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  int cyc = 0, rolls = 0, clears = 0, calc_n = 0;
  int calc_first = 0, calc_last = 0, calc_first_sel = 0;
  int calc_p [4];

  always @(negedge clock) begin
    cyc++;
    if (roll) rolls++;
    if (score_clear) clears++;
    if (calculate_score) begin
      if (calc_n == 0) begin
        calc_first     = cyc;
        calc_first_sel = int'(player_sel);
      end
      calc_last = cyc;
      calc_n++;
      calc_p[player_sel]++;
    end
  end

  task automatic clr_mon();
    rolls = 0; clears = 0; calc_n = 0;
    for (int i = 0; i < 4; i++) calc_p[i] = 0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_start(input int n);
    num_players = 3'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_ball(input int p);
    int n = 0;
    ball_pins  = 4'(p);
    ball_valid = 1'b1;
    while (!ball_ready && n < 50) begin tick(); n++; end
    chk("ready_before_ball", ball_ready, 1);
    tick();
    ball_valid = 1'b0;
    chk("roll", roll, 1);
    chk("pin_count", pin_count, p);
    tick();
  endtask

  task automatic send_bad(input int p);
    ball_pins  = 4'(p);
    ball_valid = 1'b1;
    tick();
    ball_valid = 1'b0;
    chk("error_pulse", error, 1);
    chk("no_roll_on_error", roll, 0);
    chk("ready_after_error", ball_ready, 1);
    tick();
    chk("error_one_cycle", error, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!game_over && n < 200) begin tick(); n++; end
    chk("game_over", game_over, 1);
  endtask

  initial begin
    // reset and idle
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("rst_ready", ball_ready, 0);
    chk("rst_frame", frame, 0);
    chk("rst_ball_num", ball_num, 0);
    chk("rst_strobes", {roll, score_clear, calculate_score, error, game_over}, 0);
    chk("rst_pins_sel", {pin_count, player_sel}, 0);

    // solo gutter game
    clr_mon();
    do_start(1);
    chk("clr_pulse", score_clear, 1);
    chk("clr_frame", frame, 1);
    chk("clr_ball", ball_num, 1);
    chk("clr_ready", ball_ready, 0);
    tick();
    chk("clr_done", score_clear, 0);
    chk("wait_ready", ball_ready, 1);
    for (int i = 0; i < 20; i++) begin
      send_ball(0);
      if (i % 2 == 1 && i < 19) chk("gutter_frame", frame, (i + 1) / 2 + 1);
    end
    chk("gutter_final_frame", frame, 10);
    chk("gutter_final_ball", ball_num, 2);
    chk("gutter_scoring", calculate_score, 1);
    wait_done();
    chk("gutter_rolls", rolls, 20);
    chk("gutter_clears", clears, 1);
    chk("gutter_calc", calc_n, 10);
    chk("gutter_calc_p0", calc_p[0], 10);
    chk("gutter_done_ready", ball_ready, 0);
    chk("gutter_done_calc", calculate_score, 0);

    // perfect game, then an extra ball that must never be taken
    clr_mon();
    do_start(1);
    chk("restart_game_over", game_over, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      send_ball(10);
      if (i == 10) begin
        chk("perfect_ball3", ball_num, 3);
        chk("perfect_frame10", frame, 10);
      end
    end
    ball_pins  = 4'd10;
    ball_valid = 1'b1;
    wait_done();
    tick(3);
    ball_valid = 1'b0;
    chk("perfect_rolls", rolls, 12);
    chk("perfect_calc", calc_n, 10);
    chk("perfect_ready", ball_ready, 0);

    // illegal balls
    do_start(1);
    tick();
    send_ball(7);
    chk("err_ball_num_pre", ball_num, 2);
    send_bad(4);
    chk("err_ball_num_hold", ball_num, 2);
    chk("err_frame_hold", frame, 1);
    send_ball(3);
    chk("err_next_frame", frame, 2);
    chk("err_next_ball", ball_num, 1);
    send_bad(11);
    chk("err11_frame", frame, 2);
    chk("err11_ball", ball_num, 1);

    // two players
    clr_mon();
    do_start(2);
    tick();
    send_ball(10);
    chk("p2_sel_after_strike", player_sel, 1);
    chk("p2_frame_after_strike", frame, 1);
    send_ball(5);
    chk("p2_p1_ball2", ball_num, 2);
    send_ball(5);
    chk("p2_sel_wrap", player_sel, 0);
    chk("p2_frame2", frame, 2);
    for (int i = 0; i < 36; i++) send_ball(0);
    wait_done();
    chk("p2_calc_p0", calc_p[0], 10);
    chk("p2_calc_p1", calc_p[1], 10);
    chk("p2_calc_total", calc_n, 20);
    chk("p2_calc_contig", calc_last - calc_first + 1, 20);
    chk("p2_calc_first_sel", calc_first_sel, 0);

    // restart from the middle of frame 4
    do_start(3);
    tick();
    for (int i = 0; i < 18; i++) send_ball(0);
    chk("mid_frame4", frame, 4);
    send_ball(0);
    send_ball(0);
    send_ball(0);
    chk("mid_sel1", player_sel, 1);
    chk("mid_ball2", ball_num, 2);
    clr_mon();
    do_start(3);
    chk("mid_clr", score_clear, 1);
    chk("mid_frame", frame, 1);
    chk("mid_ball", ball_num, 1);
    chk("mid_sel", player_sel, 0);
    chk("mid_game_over", game_over, 0);
    tick();
    send_ball(10);
    send_ball(10);
    chk("mid_sel2", player_sel, 2);
    send_ball(10);
    chk("mid_wrap_sel", player_sel, 0);
    chk("mid_wrap_frame", frame, 2);
    chk("mid_clears", clears, 1);

    // zero players acts as one
    do_start(0);
    tick();
    send_ball(10);
    chk("np0_sel", player_sel, 0);
    chk("np0_frame", frame, 2);

    // seven players clamps to four
    do_start(7);
    tick();
    for (int i = 0; i < 3; i++) send_ball(10);
    chk("np7_sel3", player_sel, 3);
    chk("np7_frame1", frame, 1);
    send_ball(10);
    chk("np7_sel0", player_sel, 0);
    chk("np7_frame2", frame, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
